// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: turns decoder outputs into one-cycle datapath strobes,
// handles sms/smc skip, wfi/rfi, single-level interrupt entry and retired-instruction count.
module instr_sequencer #(
  parameter int unsigned         PC_WIDTH   = 12,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = 'h004,
  parameter int unsigned         CNT_WIDTH  = 16
) (
  input  logic                 mem_clock,
  input  logic                 reset_bar,
  input  logic [4:0]           opcode,
  input  logic [1:0]           w_mux_in,
  input  logic                 mem_write_in,
  input  logic [1:0]           pc_mux_in,
  input  logic                 alu_skip,
  input  logic                 irq,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 ir_load,
  output logic                 w_load,
  output logic                 mem_we,
  output logic                 pc_load,
  output logic [2:0]           pc_sel,
  output logic [PC_WIDTH-1:0]  shadow_pc,
  output logic [PC_WIDTH-1:0]  vector_addr,
  output logic                 in_isr,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WAIT  = 2'd2,
    S_IRQ   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_INC    = 3'd0;
  localparam logic [2:0] SEL_W      = 3'd1;
  localparam logic [2:0] SEL_LIT    = 3'd2;
  localparam logic [2:0] SEL_SHADOW = 3'd3;
  localparam logic [2:0] SEL_VECTOR = 3'd4;
  localparam logic [2:0] SEL_SKIP   = 3'd5;

  localparam logic [1:0] PCM_ADD  = 2'd0;
  localparam logic [1:0] PCM_WREG = 2'd1;
  localparam logic [1:0] PCM_LIT  = 2'd2;
  localparam logic [1:0] PCM_SAVE = 2'd3;

  localparam logic [1:0] WM_HOLD = 2'd3;

  state_t                state_q, state_d;
  logic                  in_isr_q, in_isr_d;
  logic [PC_WIDTH-1:0]   shadow_pc_q, shadow_pc_d;
  logic [CNT_WIDTH-1:0]  instr_count_q, instr_count_d;

  logic                  is_skip_op;
  logic                  is_rfi;
  logic                  is_wfi;

  // Opcode classes; the low opcode bit distinguishes variants that share control flow.
  always_comb begin
    is_skip_op = 1'b0;
    is_rfi     = 1'b0;
    is_wfi     = 1'b0;
    casez (opcode)
      5'b1010?, 5'b1011?: is_skip_op = 1'b1;
      5'b1111?:           is_rfi     = 1'b1;
      5'b1110?:           is_wfi     = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge mem_clock or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q       <= S_FETCH;
      in_isr_q      <= 1'b0;
      shadow_pc_q   <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_isr_q      <= in_isr_d;
      shadow_pc_q   <= shadow_pc_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_isr_d      = in_isr_q;
    shadow_pc_d   = shadow_pc_q;
    instr_count_d = instr_count_q;
    ir_load       = 1'b0;
    w_load        = 1'b0;
    mem_we        = 1'b0;
    pc_load       = 1'b0;
    pc_sel        = SEL_INC;

    unique case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        mem_we        = mem_write_in;
        w_load        = (w_mux_in != WM_HOLD);
        pc_load       = 1'b1;
        instr_count_d = instr_count_q + CNT_WIDTH'(1);
        unique case (pc_mux_in)
          PCM_ADD:  pc_sel = (is_skip_op && alu_skip) ? SEL_SKIP : SEL_INC;
          PCM_WREG: pc_sel = SEL_W;
          PCM_LIT:  pc_sel = SEL_LIT;
          PCM_SAVE: begin
            // Only rfi returns through the shadow; wfi and anything else just advance.
            if (is_rfi) begin
              pc_sel   = SEL_SHADOW;
              in_isr_d = 1'b0;
            end else begin
              pc_sel = SEL_INC;
            end
          end
          default:  pc_sel = SEL_INC;
        endcase
        // Uses the registered in_isr, so rfi's own cycle still masks a pending irq.
        if (pc_mux_in == PCM_SAVE && is_wfi && !in_isr_q) begin
          state_d = S_WAIT;
        end else if (irq && !in_isr_q) begin
          state_d = S_IRQ;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WAIT: begin
        if (irq) begin
          state_d = S_IRQ;
        end
      end

      S_IRQ: begin
        pc_load     = 1'b1;
        pc_sel      = SEL_VECTOR;
        shadow_pc_d = pc;
        in_isr_d    = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Strobes must be quiet for the whole time reset is asserted.
    if (!reset_bar) begin
      ir_load = 1'b0;
      w_load  = 1'b0;
      mem_we  = 1'b0;
      pc_load = 1'b0;
      pc_sel  = SEL_INC;
    end
  end

  assign shadow_pc   = shadow_pc_q;
  assign in_isr      = in_isr_q;
  assign instr_count = instr_count_q;
  assign vector_addr = IRQ_VECTOR;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; inputs change on the falling edge.
module tb_instr_sequencer;

  logic        mem_clock;
  logic        reset_bar;
  logic [4:0]  opcode;
  logic [1:0]  w_mux_in;
  logic        mem_write_in;
  logic [1:0]  pc_mux_in;
  logic        alu_skip;
  logic        irq;
  logic [11:0] pc;
  logic        ir_load;
  logic        w_load;
  logic        mem_we;
  logic        pc_load;
  logic [2:0]  pc_sel;
  logic [11:0] shadow_pc;
  logic [11:0] vector_addr;
  logic        in_isr;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  instr_sequencer dut (
    .mem_clock    (mem_clock),
    .reset_bar    (reset_bar),
    .opcode       (opcode),
    .w_mux_in     (w_mux_in),
    .mem_write_in (mem_write_in),
    .pc_mux_in    (pc_mux_in),
    .alu_skip     (alu_skip),
    .irq          (irq),
    .pc           (pc),
    .ir_load      (ir_load),
    .w_load       (w_load),
    .mem_we       (mem_we),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .shadow_pc    (shadow_pc),
    .vector_addr  (vector_addr),
    .in_isr       (in_isr),
    .instr_count  (instr_count)
  );

  initial mem_clock = 1'b0;
  always #5 mem_clock = ~mem_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {ir_load, w_load, mem_we, pc_load, pc_sel}.
  task automatic chk_strobes(input string tag, input logic ir, input logic w, input logic we,
                             input logic pl, input logic [2:0] sel);
    chk(tag, {25'd0, ir_load, w_load, mem_we, pc_load, pc_sel}, {25'd0, ir, w, we, pl, sel});
  endtask

  // Entered on a falling edge while in FETCH; leaves on the falling edge after EXEC.
  task automatic do_instr(input string tag, input logic [4:0] op, input logic [1:0] wm,
                          input logic mw, input logic [1:0] pm, input logic sk, input logic irqv,
                          input logic exp_w, input logic exp_we, input logic [2:0] exp_sel);
    opcode = op; w_mux_in = wm; mem_write_in = mw; pc_mux_in = pm; alu_skip = sk; irq = irqv;
    #1;
    chk_strobes({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
    @(negedge mem_clock);
    #1;
    chk_strobes({tag, "_exec"}, 1'b0, exp_w, exp_we, 1'b1, exp_sel);
    exp_cnt++;
    @(negedge mem_clock);
  endtask

  // Entered on a falling edge while in IRQ.
  task automatic irq_entry(input string tag, input logic [11:0] exp_shadow);
    #1;
    chk_strobes({tag, "_irq"}, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    @(negedge mem_clock);
    #1;
    chk({tag, "_shadow"}, 32'(shadow_pc), 32'(exp_shadow));
    chk({tag, "_in_isr"}, 32'(in_isr), 32'd1);
  endtask

  initial begin
    reset_bar = 1'b0; opcode = 5'h00; w_mux_in = 2'd3; mem_write_in = 1'b0;
    pc_mux_in = 2'd0; alu_skip = 1'b0; irq = 1'b0; pc = 12'h000;
    repeat (3) @(negedge mem_clock);
    #1;
    chk_strobes("reset_strobes", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_shadow", 32'(shadow_pc), 32'd0);
    chk("reset_in_isr", 32'(in_isr), 32'd0);
    chk("vector_addr", 32'(vector_addr), 32'h004);
    @(negedge mem_clock);
    reset_bar = 1'b1;

    do_instr("mlw", 5'h04, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    do_instr("mm_store", 5'h01, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    do_instr("sms_skip", 5'h14, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
    do_instr("sms_noskip", 5'h14, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    do_instr("goto_w", 5'h10, 2'd3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    do_instr("goto_lit", 5'h12, 2'd3, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);

    // irq sampled in EXEC of an add
    pc = 12'h020;
    do_instr("add_irq", 5'h08, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    irq_entry("entry1", 12'h020);
    chk("count_after_irq", 32'(instr_count), 32'(exp_cnt));

    // irq held high: masked inside the ISR and during rfi's own cycle
    pc = 12'h031;
    do_instr("isr_add", 5'h08, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    do_instr("rfi", 5'h1E, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    chk("rfi_in_isr", 32'(in_isr), 32'd0);
    do_instr("post_rfi_add", 5'h08, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    irq_entry("entry2", 12'h031);

    // wfi inside the ISR is a NOP; the next do_instr checks FETCH follows directly
    do_instr("wfi_in_isr", 5'h1C, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    do_instr("rfi2", 5'h1E, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);

    // wfi outside the ISR parks in WAIT until irq
    pc = 12'h045;
    do_instr("wfi", 5'h1C, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_strobes($sformatf("wait_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      @(negedge mem_clock);
    end
    irq = 1'b1;
    #1;
    chk_strobes("wait_irq_raised", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge mem_clock);
    irq_entry("entry3", 12'h045);
    do_instr("rfi3", 5'h1E, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    chk("rfi3_in_isr", 32'(in_isr), 32'd0);

    // reset asserted in the middle of EXEC
    opcode = 5'h01; w_mux_in = 2'd3; mem_write_in = 1'b1; pc_mux_in = 2'd0;
    @(negedge mem_clock);
    #1;
    chk_strobes("pre_reset_exec", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    reset_bar = 1'b0;
    #1;
    chk_strobes("reset_mid_exec", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset_mid_count", 32'(instr_count), 32'd0);
    chk("reset_mid_shadow", 32'(shadow_pc), 32'd0);
    chk("reset_mid_in_isr", 32'(in_isr), 32'd0);
    @(negedge mem_clock);
    reset_bar = 1'b1;
    exp_cnt = 0;
    // rfi straight after reset returns to the cleared shadow
    do_instr("rfi_cold", 5'h1E, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    chk("rfi_cold_shadow", 32'(shadow_pc), 32'd0);
    chk("final_count", 32'(instr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the accumulator core. It consumes the instruction decoder's combinational outputs (w_mux, mem_write, pc_mux) and the raw opcode, and turns them into one-cycle strobes for the datapath: IR load, W load, memory write and PC load with an extended PC-source select. It also owns skip handling for sms/smc, wfi/rfi, the single-level interrupt entry with a shadow PC, and a retired-instruction counter.

Parameters:
PC_WIDTH, 12, width of PC and shadow PC.
IRQ_VECTOR, 12'h004, PC value loaded on interrupt entry.
CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
mem_clock  input  1  core clock; all state updates on the rising edge.
reset_bar  input  1  asynchronous active-low reset.
opcode  input  5  opcode field of the instruction register (valid from the cycle after ir_load).
w_mux_in  input  2  decoder W source select (0 ALU, 1 MEM, 2 LIT, 3 WREG = hold).
mem_write_in  input  1  decoder memory-write request.
pc_mux_in  input  2  decoder PC source (0 ADD, 1 WREG, 2 LIT, 3 SAVE).
alu_skip  input  1  ALU condition result for sms/smc; 1 = skip the next instruction.
irq  input  1  level-sensitive interrupt request.
pc  input  PC_WIDTH  current PC register value.
ir_load  output  1  load the instruction register from program memory.
w_load  output  1  load W from the w_mux-selected source.
mem_we  output  1  data-memory write strobe.
pc_load  output  1  load PC from pc_sel source.
pc_sel  output  3  0 PC+1, 1 W, 2 literal, 3 shadow_pc, 4 vector, 5 PC+2.
shadow_pc  output  PC_WIDTH  saved return address.
vector_addr  output  PC_WIDTH  constant IRQ_VECTOR.
in_isr  output  1  1 while servicing an interrupt (masks irq).
instr_count  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: FETCH, EXEC, WAIT, IRQ. Outputs ir_load, w_load, mem_we, pc_load and pc_sel are combinational from the state and inputs. All strobes are forced to 0 while reset_bar=0.
- Reset, asynchronous: state=FETCH, in_isr=0, shadow_pc=0, instr_count=0. Reset mid-instruction abandons it with no write.
- FETCH: ir_load=1, other strobes 0, next state EXEC.
- EXEC: mem_we=mem_write_in. w_load=(w_mux_in!=3). pc_load=1. instr_count increments with wrap-around. pc_sel is chosen as follows:
  - pc_mux_in=0 and opcode[4:1] in {A,B}: 5 if alu_skip, else 0.
  - pc_mux_in=0, other opcodes: 0.
  - pc_mux_in=1: 1.
  - pc_mux_in=2: 2.
  - pc_mux_in=3, opcode[4:1]=F (rfi): 3; in_isr is cleared at the end of the cycle.
  - pc_mux_in=3, opcode[4:1]=E (wfi): 0.
- EXEC next state:
  - wfi with in_isr=0 goes to WAIT.
  - Otherwise irq=1 and in_isr=0 (sampled in EXEC) goes to IRQ.
  - Otherwise FETCH.
  - rfi's own EXEC cycle still sees the old in_isr=1, so a pending irq is taken after the next instruction, never immediately.
- wfi with in_isr=1 behaves as a NOP: PC+1, then FETCH.
- WAIT: all strobes 0. irq=1 goes to IRQ; otherwise stay in WAIT.
- IRQ: shadow_pc<=pc (the address of the next unexecuted instruction), pc_load=1, pc_sel=4, in_isr<=1, next state FETCH. Not counted in instr_count.
- Latency: 2 cycles per instruction; interrupt entry adds 1 cycle.
- No nesting: irq is ignored while in_isr=1. rfi with in_isr=0 still loads shadow_pc, which is 0 after reset.

Test Plan:
- Reset, then release with opcode=5'h04 (mlw), w_mux_in=2 -> cycle 1 ir_load=1; cycle 2 w_load=1, pc_load=1, pc_sel=0, mem_we=0; instr_count=1.
- mm store (opcode 5'h01, w_mux_in=3, mem_write_in=1) -> in EXEC mem_we=1, w_load=0, pc_sel=0.
- sms (opcode 5'h14) with alu_skip=1 -> pc_sel=5; repeat with alu_skip=0 -> pc_sel=0.
- irq=1 during EXEC of add with pc=12'h020 -> next state IRQ, shadow_pc=12'h020, pc_sel=4, in_isr=1. A later rfi gives pc_sel=3 and in_isr=0. irq held high throughout -> re-entry only after one further instruction.
- wfi (opcode 5'h1C) at in_isr=0 -> pc_sel=0, then WAIT with all strobes 0 for 5 cycles; raise irq -> IRQ next cycle. wfi at in_isr=1 -> FETCH, no WAIT.
- Pull reset_bar low during EXEC -> strobes drop to 0 immediately; after release state=FETCH, instr_count=0, shadow_pc=0.
